// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port onto a
// single cache-line memory port, with a per-transfer timeout and one-cycle acks.
module cpu_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

   state_t                r_state;
   owner_t                r_owner;
   owner_t                r_last_grant;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic [15:0]           r_wait;
   logic                  r_mem_req;
   logic                  r_busy;
   logic                  r_i_ack;
   logic                  r_i_err;
   logic [LINE_WIDTH-1:0] r_i_rdata;
   logic                  r_d_ack;
   logic                  r_d_err;
   logic [LINE_WIDTH-1:0] r_d_rdata;

   owner_t                w_grant;
   logic                  w_timeout;

   // On a tie the side that was not granted last time wins.
   always_comb begin
      w_grant   = (d_req && !(i_req && r_last_grant == OWN_D)) ? OWN_D : OWN_I;
      w_timeout = (r_wait == LAST_WAIT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= OWN_I;
         r_last_grant <= OWN_D;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_wait       <= '0;
         r_mem_req    <= 1'b0;
         r_busy       <= 1'b0;
         r_i_ack      <= 1'b0;
         r_i_err      <= 1'b0;
         r_i_rdata    <= '0;
         r_d_ack      <= 1'b0;
         r_d_err      <= 1'b0;
         r_d_rdata    <= '0;
      end else begin
         r_i_ack <= 1'b0;
         r_i_err <= 1'b0;
         r_d_ack <= 1'b0;
         r_d_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_req || d_req) begin
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
                  r_addr       <= (w_grant == OWN_D) ? d_addr : i_addr;
                  r_we         <= (w_grant == OWN_D) && d_we;
                  r_wdata      <= (w_grant == OWN_D) ? d_wdata : '0;
                  r_wait       <= '0;
                  r_mem_req    <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= BUSY;
               end
            end
            BUSY: begin
               if (!mem_ready) r_wait <= r_wait + 16'd1;
               // mem_ready takes priority over a coincident timeout
               if (mem_ready || w_timeout) begin
                  r_state   <= RESP;
                  r_mem_req <= 1'b0;
                  if (r_owner == OWN_D) begin
                     r_d_ack <= 1'b1;
                     r_d_err <= !mem_ready;
                     if (mem_ready && !r_we) r_d_rdata <= mem_rdata;
                  end else begin
                     r_i_ack <= 1'b1;
                     r_i_err <= !mem_ready;
                     if (mem_ready) r_i_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_mem_req <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = r_busy;
   assign i_ack     = r_i_ack;
   assign i_err     = r_i_err;
   assign i_rdata   = r_i_rdata;
   assign d_ack     = r_d_ack;
   assign d_err     = r_d_err;
   assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_cpu_mem_arbiter;
   localparam int AW  = 32;
   localparam int LW  = 128;
   localparam int TMO = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_ack, i_err;
   logic [LW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [LW-1:0] d_wdata = '0;
   logic          d_ack, d_err;
   logic [LW-1:0] d_rdata;
   logic          mem_req, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [LW-1:0] mem_rdata = '0;

   cpu_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk1(string name, logic act, logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   function automatic void chka(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void chkw(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void chki(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // stimulus configuration, written only by the main sequence (posedge + #1)
   bit            directed = 1'b1;
   bit            noise = 1'b0;
   bit            force_ready = 1'b0;
   int            mem_delay = 3;
   int            gapmax = 0;
   int            i_budget = 0;
   int            d_budget = 0;
   logic [AW-1:0] cfg_i_addr = '0;
   logic [AW-1:0] cfg_d_addr = '0;
   logic          cfg_d_we = 1'b0;
   logic [LW-1:0] cfg_d_wdata = '0;
   logic [LW-1:0] cfg_rdata = '0;

   // fetch requester: holds req until ack, drops it in the ack cycle
   int i_used = 0, i_wait = 0;
   always @(negedge clock) begin
      if (reset) i_req = 1'b0;
      else if (i_req) begin
         if (i_ack) begin
            i_req  = 1'b0;
            i_wait = $urandom_range(0, gapmax);
         end
      end else if (i_used < i_budget) begin
         if (i_wait > 0) i_wait--;
         else begin
            i_req  = 1'b1;
            i_used++;
            i_addr = directed ? cfg_i_addr : AW'($urandom);
         end
      end
   end

   int d_used = 0, d_wait = 0;
   always @(negedge clock) begin
      if (reset) d_req = 1'b0;
      else if (d_req) begin
         if (d_ack) begin
            d_req  = 1'b0;
            d_wait = $urandom_range(0, gapmax);
         end
      end else if (d_used < d_budget) begin
         if (d_wait > 0) d_wait--;
         else begin
            d_req   = 1'b1;
            d_used++;
            d_addr  = directed ? cfg_d_addr : AW'($urandom);
            d_we    = directed ? cfg_d_we : 1'($urandom_range(0, 1));
            d_wdata = directed ? cfg_d_wdata : {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // memory: answers on the mem_delay-th cycle of mem_req (0 = never)
   int bcnt = 0, cur_delay = 0;
   always @(negedge clock) begin
      if (mem_req) begin
         if (bcnt == 0) cur_delay = directed ? mem_delay : $urandom_range(0, 10);
         bcnt++;
         mem_ready = force_ready || (bcnt == cur_delay);
      end else begin
         bcnt      = 0;
         mem_ready = force_ready || (noise && $urandom_range(0, 3) == 0);
      end
      mem_rdata = directed ? cfg_rdata : {$urandom, $urandom, $urandom, $urandom};
   end

   // Reference model: tracks the single outstanding transfer as a record
   // (owner, elapsed busy cycles) and derives expected outputs from it.
   bit            m_on = 1'b0, m_act = 1'b0, m_resp = 1'b0, m_last_d = 1'b1, m_own_d = 1'b0;
   int            m_elapsed = 0;
   bit            g_log[$];
   logic          e_mem_req, e_mem_we, e_busy, e_i_ack, e_d_ack, e_i_err, e_d_err;
   logic [AW-1:0] e_mem_addr;
   logic [LW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

   always @(posedge clock) begin
      if (reset) begin
         m_on = 1'b1; m_act = 1'b0; m_resp = 1'b0; m_last_d = 1'b1;
         e_mem_req = 1'b0; e_mem_we = 1'b0; e_busy = 1'b0;
         e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
         e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
      end else if (m_on) begin
         e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
         if (m_resp) m_resp = 1'b0;
         else if (m_act) begin
            m_elapsed++;
            if (mem_ready || m_elapsed >= TMO) begin
               m_act  = 1'b0;
               m_resp = 1'b1;
               if (m_own_d) begin
                  e_d_ack = 1'b1;
                  e_d_err = !mem_ready;
                  if (mem_ready && !e_mem_we) e_d_rdata = mem_rdata;
               end else begin
                  e_i_ack = 1'b1;
                  e_i_err = !mem_ready;
                  if (mem_ready) e_i_rdata = mem_rdata;
               end
            end
         end else if (i_req || d_req) begin
            m_own_d     = (d_req && !i_req) || (i_req && d_req && !m_last_d);
            m_last_d    = m_own_d;
            g_log.push_back(m_own_d);
            m_act       = 1'b1;
            m_elapsed   = 0;
            e_mem_addr  = m_own_d ? d_addr : i_addr;
            e_mem_we    = m_own_d && d_we;
            e_mem_wdata = m_own_d ? d_wdata : '0;
         end
         e_mem_req = m_act;
         e_busy    = m_act || m_resp;
      end
   end

   always @(negedge clock) begin
      if (m_on) begin
         chk1("mem_req", mem_req, e_mem_req);
         chk1("mem_we", mem_we, e_mem_we);
         chka("mem_addr", mem_addr, e_mem_addr);
         chkw("mem_wdata", mem_wdata, e_mem_wdata);
         chk1("busy", busy, e_busy);
         chk1("i_ack", i_ack, e_i_ack);
         chk1("i_err", i_err, e_i_err);
         chkw("i_rdata", i_rdata, e_i_rdata);
         chk1("d_ack", d_ack, e_d_ack);
         chk1("d_err", d_err, e_d_err);
         chkw("d_rdata", d_rdata, e_d_rdata);
      end
   end

   // waits for mem_req, then counts its cycles; returns on the ack cycle
   task automatic xfer(output int nwait, output int nbusy);
      nwait = 0;
      nbusy = 0;
      do begin
         @(negedge clock);
         nwait++;
      end while (!mem_req && nwait < 40);
      if (!mem_req) begin
         chk1("xfer_start", mem_req, 1'b1);
         return;
      end
      while (mem_req && nbusy < 300) begin
         nbusy++;
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock);
      @(posedge clock); #1 reset = 1'b0;
   endtask

   int nw, nb, base, t;

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chkw("rst_i_rdata", i_rdata, '0);

      // single fetch
      @(posedge clock); #1;
      cfg_i_addr = 32'h0000_1000; cfg_rdata = {16{8'hA5}}; mem_delay = 3; i_budget++;
      xfer(nw, nb);
      chki("t1_busy_cycles", nb, 3);
      chk1("t1_i_ack", i_ack, 1'b1);
      chk1("t1_i_err", i_err, 1'b0);
      chk1("t1_d_ack", d_ack, 1'b0);
      chkw("t1_i_rdata", i_rdata, {16{8'hA5}});
      chka("t1_mem_addr", mem_addr, 32'h0000_1000);
      chk1("t1_mem_we", mem_we, 1'b0);
      @(negedge clock);
      chk1("t1_ack_one_cycle", i_ack, 1'b0);

      // tie after reset: fetch first, then the write-back
      do_reset();
      cfg_i_addr = 32'h0000_3000; cfg_d_addr = 32'h0000_2000; cfg_d_we = 1'b1;
      cfg_d_wdata = {4{32'hDEAD_BEEF}}; mem_delay = 2; i_budget++; d_budget++;
      xfer(nw, nb);
      chk1("t2_fetch_first", i_ack, 1'b1);
      chk1("t2_no_d_ack", d_ack, 1'b0);
      chka("t2_fetch_addr", mem_addr, 32'h0000_3000);
      xfer(nw, nb);
      chki("t2_gap", nw, 2);
      chk1("t2_d_ack", d_ack, 1'b1);
      chk1("t2_mem_we", mem_we, 1'b1);
      chka("t2_d_addr", mem_addr, 32'h0000_2000);
      chkw("t2_wdata", mem_wdata, {4{32'hDEAD_BEEF}});
      chkw("t2_d_rdata_kept", d_rdata, '0);

      // four back-to-back ties
      @(posedge clock); #1;
      cfg_d_we = 1'b0; mem_delay = 1; base = g_log.size(); i_budget += 2; d_budget += 2;
      for (int r = 0; r < 4; r++) begin
         xfer(nw, nb);
         if (r > 0) chki("t3_gap", nw, 2);
         chk1("t3_i_ack", i_ack, r % 2 == 0);
         chk1("t3_d_ack", d_ack, r % 2 == 1);
      end
      chki("t3_grants", g_log.size() - base, 4);
      for (int r = 0; r < 4 && base + r < g_log.size(); r++)
         chk1("t3_order", g_log[base + r], r % 2 == 1);

      // timeout keeps previous d_rdata
      @(posedge clock); #1;
      cfg_rdata = {16{8'h5A}}; mem_delay = 2; d_budget++;
      xfer(nw, nb);
      chkw("t4_prefill", d_rdata, {16{8'h5A}});
      @(posedge clock); #1;
      cfg_rdata = {16{8'hFF}}; mem_delay = 0; d_budget++;
      xfer(nw, nb);
      chki("t4_timeout_cycles", nb, 8);
      chk1("t4_d_ack", d_ack, 1'b1);
      chk1("t4_d_err", d_err, 1'b1);
      chkw("t4_d_rdata_kept", d_rdata, {16{8'h5A}});
      chk1("t4_i_ack", i_ack, 1'b0);

      // ready on the last allowed cycle wins over timeout
      @(posedge clock); #1;
      cfg_rdata = {16{8'h3C}}; mem_delay = 8; d_budget++;
      xfer(nw, nb);
      chki("t5_cycles", nb, 8);
      chk1("t5_d_ack", d_ack, 1'b1);
      chk1("t5_d_err", d_err, 1'b0);
      chkw("t5_d_rdata", d_rdata, {16{8'h3C}});

      // reset on the second busy cycle
      @(posedge clock); #1;
      mem_delay = 0; d_budget++;
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!mem_req && t < 40);
      @(negedge clock);
      chk1("t6_second_busy", mem_req, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      chk1("t6_mem_req", mem_req, 1'b0);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_d_ack", d_ack, 1'b0);
      chka("t6_mem_addr", mem_addr, '0);
      chkw("t6_d_rdata", d_rdata, '0);
      @(posedge clock); #1 reset = 1'b0; force_ready = 1'b1;
      @(posedge clock); #1 force_ready = 1'b0;
      repeat (4) begin
         @(negedge clock);
         chk1("t6_no_ack", i_ack | d_ack, 1'b0);
         chk1("t6_idle", busy, 1'b0);
      end

      // randomized traffic
      @(posedge clock); #1;
      directed = 1'b0; noise = 1'b1; gapmax = 3; i_budget += 40; d_budget += 40;
      t = 0;
      while (!(i_used == i_budget && d_used == d_budget && !i_req && !d_req && !busy) && t < 6000) begin
         @(negedge clock);
         t++;
      end
      chk1("rand_drained", t < 6000, 1'b1);
      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
